mb_writeback: RTL and testbench

Serializes one processed macroblock into a stream of 32-bit words over a valid/ready handshake. The macroblock is a 16x16 luma array plus two 8x8 chroma arrays. The block sits at the output of the EPU pipeline, opposite the fetch stage. It emits words in exactly the order and byte packing that the fetch stage consumes, so a written-back macroblock can be re-fetched unchanged.

---
 rtl/mb_writeback_if.sv | 24 ++
 rtl/mb_writeback.sv | 194 +++++++++++++++++++
 tb/tb_mb_writeback.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mb_writeback_if.sv
// mb_writeback_if
// Word stream from the writeback block to the downstream sink.
//   data_word  : current outgoing 32-bit word (driven by master)
//   data_valid : data_word holds a valid word (driven by master)
//   data_ready : sink accepts data_word this cycle (driven by slave)
// A word transfers on any rising clock edge where data_valid && data_ready.

interface mb_writeback_if;
  logic [31:0] data_word;
  logic        data_valid;
  logic        data_ready;

  modport master (
    output data_word,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_word,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/mb_writeback.sv
// mb_writeback
// Serializes one macroblock (Y 16x16, U/V 8x8, 8-bit samples) into 96
// 32-bit words: 32 groups of {Y row word, next Y row word, UV word}. The
// order and byte packing match what the fetch stage consumes, so a
// written-back macroblock can be re-fetched unchanged.
//
// Ports:
//   clk       : clock, rising-edge
//   rst       : asynchronous reset, active-low
//   wb_start  : start one writeback; only sampled while idle
//   pixel_y   : luma samples, indexed [x][y]
//   pixel_u   : Cb samples, indexed [x][y]
//   pixel_v   : Cr samples, indexed [x][y]
//   wb        : word stream (master side of mb_writeback_if)
//   wb_busy   : high whenever the block is not idle
//   wb_finish : one-cycle pulse in the cycle after the last word
//
// Build option WB_SNAPSHOT_EN: when defined, the pixel arrays are copied
// into internal registers on the start edge and the words are packed from
// that copy, so upstream may change the arrays right after start. When
// undefined, words are packed from the live inputs, which must then stay
// stable from wb_start until wb_finish.

module mb_writeback (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_start,
  input  logic [15:0][15:0][7:0]  pixel_y,
  input  logic [7:0][7:0][7:0]    pixel_u,
  input  logic [7:0][7:0][7:0]    pixel_v,
  mb_writeback_if.master          wb,
  output logic                    wb_busy,
  output logic                    wb_finish
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_Y1,
    SEND_Y2,
    SEND_UV,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  group_q;
  logic [4:0]  group_d;

  logic        handshake;
  logic        startAccept;
  logic [31:0] dataWord;

  logic [3:0]  lumaX0;
  logic [3:0]  lumaX1;
  logic [3:0]  lumaX2;
  logic [3:0]  lumaX3;
  logic [3:0]  lumaY;
  logic [2:0]  chromaX0;
  logic [2:0]  chromaX1;
  logic [2:0]  chromaY;

  logic [15:0][15:0][7:0] srcY;
  logic [7:0][7:0][7:0]   srcU;
  logic [7:0][7:0][7:0]   srcV;

  assign handshake   = wb.data_valid && wb.data_ready;
  assign startAccept = (state_q == IDLE) && wb_start;

  // Status outputs are decoded from the registered state only, so
  // data_valid never has a combinational path from data_ready.
  assign wb.data_valid = (state_q == SEND_Y1) || (state_q == SEND_Y2) ||
                         (state_q == SEND_UV);
  assign wb_busy       = (state_q != IDLE);
  assign wb_finish     = (state_q == DONE);
  assign wb.data_word  = dataWord;

  // State and group counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      group_q <= 5'd0;
    end else begin
      state_q <= state_d;
      group_q <= group_d;
    end
  end

  // Next-state logic: each SEND state advances only on a handshake, and
  // the group counter steps after the UV word of each group.
  always_comb begin
    state_d = state_q;
    group_d = group_q;
    case (state_q)
      IDLE: begin
        if (wb_start) begin
          state_d = SEND_Y1;
          group_d = 5'd0;
        end
      end
      SEND_Y1: begin
        if (handshake) begin
          state_d = SEND_Y2;
        end
      end
      SEND_Y2: begin
        if (handshake) begin
          state_d = SEND_UV;
        end
      end
      SEND_UV: begin
        if (handshake) begin
          if (group_q == 5'd31) begin
            state_d = DONE;
          end else begin
            group_d = group_q + 5'd1;
            state_d = SEND_Y1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef WB_SNAPSHOT_EN
  logic [15:0][15:0][7:0] snapY_q;
  logic [7:0][7:0][7:0]   snapU_q;
  logic [7:0][7:0][7:0]   snapV_q;

  // Capture the whole macroblock on the start edge so upstream is free
  // to reuse its buffers while the words drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snapY_q <= '0;
      snapU_q <= '0;
      snapV_q <= '0;
    end else if (startAccept) begin
      snapY_q <= pixel_y;
      snapU_q <= pixel_u;
      snapV_q <= pixel_v;
    end
  end

  assign srcY = snapY_q;
  assign srcU = snapU_q;
  assign srcV = snapV_q;
`else
  logic unusedStart;

  assign unusedStart = startAccept;
  assign srcY = pixel_y;
  assign srcU = pixel_u;
  assign srcV = pixel_v;
`endif

  // Group geometry: g[2:1] selects the column block, g[4:3] the row block
  // and g[0] the row pair within it. x and cx are multiples of 4 and 2, so
  // the +1..+3 offsets never carry out of the index width.
  always_comb begin
    lumaX0   = {group_q[2:1], 2'b00};
    lumaX1   = lumaX0 + 4'd1;
    lumaX2   = lumaX0 + 4'd2;
    lumaX3   = lumaX0 + 4'd3;
    lumaY    = {group_q[4:3], group_q[0], (state_q == SEND_Y2)};
    chromaX0 = {group_q[2:1], 1'b0};
    chromaX1 = chromaX0 + 3'd1;
    chromaY  = {group_q[4:3], group_q[0]};
  end

  // Word packing, byte0 in bits [7:0]. The word is a pure function of the
  // registered state and the (stable) source, so it holds while stalled.
  // Outside the SEND states the word is forced to zero.
  always_comb begin
    dataWord = 32'd0;
    case (state_q)
      SEND_Y1, SEND_Y2: begin
        dataWord = {srcY[lumaX3][lumaY], srcY[lumaX2][lumaY],
                    srcY[lumaX1][lumaY], srcY[lumaX0][lumaY]};
      end
      SEND_UV: begin
        dataWord = {srcV[chromaX1][chromaY], srcV[chromaX0][chromaY],
                    srcU[chromaX1][chromaY], srcU[chromaX0][chromaY]};
      end
      default: begin
        dataWord = 32'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mb_writeback.sv
// tb_mb_writeback
// Directed bench for mb_writeback. Expected words come from an
// independent arithmetic model of the test pattern and are queued when a
// macroblock is launched, then popped on every handshake.

module tb_mb_writeback;

  logic                   clk;
  logic                   rst;
  logic                   wb_start;
  logic [15:0][15:0][7:0] pixY;
  logic [7:0][7:0][7:0]   pixU;
  logic [7:0][7:0][7:0]   pixV;
  logic                   wb_busy;
  logic                   wb_finish;

  mb_writeback_if busIf ();

  mb_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .wb_start  (wb_start),
    .pixel_y   (pixY),
    .pixel_u   (pixU),
    .pixel_v   (pixV),
    .wb        (busIf.master),
    .wb_busy   (wb_busy),
    .wb_finish (wb_finish)
  );

  int          total;
  int          bad;
  logic [31:0] sb [$];
  logic [31:0] got [0:95];
  int          nWords;
  int          finCycle;
  int          finCount;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports failures.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Common test pattern: y[x][y]=16x+y, u[x][y]=16x+y, v[x][y]=0x80+16x+y.
  task automatic applyStimulus();
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        pixY[x][y] = 8'(16 * x + y);
      end
    end
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        pixU[x][y] = 8'(16 * x + y);
        pixV[x][y] = 8'(8'h80 + 16 * x + y);
      end
    end
  endtask

  task automatic overwriteInputs();
    pixY = '1;
    pixU = '1;
    pixV = '1;
  endtask

  // Reference word k (0..95) for the common pattern.
  function automatic logic [31:0] expWord(input int k);
    int g, p, x, yy, cx, cy;
    logic [31:0] w;
    g  = k / 3;
    p  = k % 3;
    x  = 4 * ((g >> 1) & 3);
    yy = 4 * ((g >> 3) & 3) + 2 * (g & 1);
    cx = 2 * ((g >> 1) & 3);
    cy = 2 * ((g >> 3) & 3) + (g & 1);
    if (p < 2) begin
      for (int i = 0; i < 4; i++) begin
        w[8*i +: 8] = 8'(16 * (x + i) + yy + p);
      end
    end else begin
      w[7:0]   = 8'(16 * cx + cy);
      w[15:8]  = 8'(16 * (cx + 1) + cy);
      w[23:16] = 8'(8'h80 + 16 * cx + cy);
      w[31:24] = 8'(8'h80 + 16 * (cx + 1) + cy);
    end
    return w;
  endfunction

  task automatic pushExpected(input bit allOnesAfterFirst);
    sb.delete();
    for (int k = 0; k < 96; k++) begin
      if (allOnesAfterFirst && k > 0) begin
        sb.push_back(32'hFFFF_FFFF);
      end else begin
        sb.push_back(expWord(k));
      end
    end
  endtask

  // Launch one macroblock and follow it cycle by cycle on falling edges.
  // c counts cycles after the start edge N (c=1 is cycle N+1).
  task automatic runStream(input bit randReady, input int restartAt,
                           input int abortAt, input bit overwrite);
    logic [31:0] prevWord;
    logic [31:0] expd;
    bit          prevStall;
    bit          done;
    bit          restarted;
    bit          overwritten;
    bit          rdy;
    nWords      = 0;
    finCycle    = -1;
    finCount    = 0;
    prevStall   = 1'b0;
    prevWord    = 32'd0;
    done        = 1'b0;
    restarted   = 1'b0;
    overwritten = 1'b0;
    @(negedge clk);
    wb_start = 1'b1;
    @(negedge clk);
    wb_start = 1'b0;
    for (int c = 1; c <= 3000 && !done; c++) begin
      if (c > 1) @(negedge clk);
      wb_start = 1'b0;
      if (overwrite && nWords == 1 && !overwritten) begin
        overwriteInputs();
        overwritten = 1'b1;
        #1;
      end
      if (restartAt >= 0 && nWords == restartAt && !restarted) begin
        wb_start  = 1'b1;
        restarted = 1'b1;
      end
      if (abortAt >= 0 && nWords == abortAt) begin
        rst = 1'b0;
        #1;
        checkOutput("abort_valid", 32'(busIf.data_valid), 32'd0);
        checkOutput("abort_busy", 32'(wb_busy), 32'd0);
        checkOutput("abort_finish", 32'(wb_finish), 32'd0);
        checkOutput("abort_word", busIf.data_word, 32'd0);
        busIf.data_ready = 1'b0;
        return;
      end
      if (prevStall) begin
        checkOutput("stall_hold", busIf.data_word, prevWord);
      end
      if (wb_finish) begin
        finCount++;
        finCycle = c;
        checkOutput("done_valid", 32'(busIf.data_valid), 32'd0);
        wb_start = 1'b1;
      end else if (finCount > 0) begin
        checkOutput("idle_valid", 32'(busIf.data_valid), 32'd0);
        checkOutput("idle_busy", 32'(wb_busy), 32'd0);
        done = 1'b1;
      end else begin
        checkOutput("valid", 32'(busIf.data_valid), 32'd1);
        checkOutput("busy", 32'(wb_busy), 32'd1);
      end
      rdy = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      busIf.data_ready = rdy;
      if (busIf.data_valid && rdy) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          expd = sb.pop_front();
          checkOutput($sformatf("word%0d", nWords), busIf.data_word, expd);
        end
        if (nWords < 96) got[nWords] = busIf.data_word;
        nWords++;
      end
      prevStall = busIf.data_valid && !rdy;
      prevWord  = busIf.data_word;
    end
    checkOutput("timeout", 32'(done), 32'd1);
    // wb_start raised during DONE must not launch a new macroblock
    @(negedge clk);
    checkOutput("done_start_ignored", 32'(wb_busy), 32'd0);
    busIf.data_ready = 1'b0;
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    rst              = 1'b0;
    wb_start         = 1'b0;
    busIf.data_ready = 1'b0;
    applyStimulus();

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 32'(busIf.data_valid), 32'd0);
    checkOutput("rst_busy", 32'(wb_busy), 32'd0);
    checkOutput("rst_finish", 32'(wb_finish), 32'd0);
    checkOutput("rst_word", busIf.data_word, 32'd0);
    rst = 1'b1;

    // Full macroblock, sink always ready
    $display("[TB] full macroblock, ready held high");
    pushExpected(1'b0);
    runStream(1'b0, -1, -1, 1'b0);
    checkOutput("count_full", 32'(nWords), 32'd96);
    checkOutput("finish_cycle", 32'(finCycle), 32'd97);
    checkOutput("finish_pulses", 32'(finCount), 32'd1);
    checkOutput("first0", got[0], 32'h3020_1000);
    checkOutput("first1", got[1], 32'h3121_1101);
    checkOutput("first2", got[2], 32'h9080_1000);
    checkOutput("last0", got[93], 32'hFEEE_DECE);
    checkOutput("last1", got[94], 32'hFFEF_DFCF);
    checkOutput("last2", got[95], 32'hF7E7_7767);
    checkOutput("sb_empty_full", 32'(sb.size()), 32'd0);

    // Random backpressure
    $display("[TB] random backpressure");
    pushExpected(1'b0);
    runStream(1'b1, -1, -1, 1'b0);
    checkOutput("count_bp", 32'(nWords), 32'd96);
    checkOutput("finish_pulses_bp", 32'(finCount), 32'd1);
    checkOutput("sb_empty_bp", 32'(sb.size()), 32'd0);

    // Second start at group 10 must be ignored
    $display("[TB] restart attempt mid-stream");
    pushExpected(1'b0);
    runStream(1'b0, 30, -1, 1'b0);
    checkOutput("count_restart", 32'(nWords), 32'd96);
    checkOutput("finish_cycle_restart", 32'(finCycle), 32'd97);
    checkOutput("sb_empty_restart", 32'(sb.size()), 32'd0);

    // Reset at word 40, then stay idle without a start
    $display("[TB] reset mid-stream");
    pushExpected(1'b0);
    runStream(1'b0, -1, 40, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("post_rst_valid", 32'(busIf.data_valid), 32'd0);
      checkOutput("post_rst_busy", 32'(wb_busy), 32'd0);
    end
    pushExpected(1'b0);
    runStream(1'b0, -1, -1, 1'b0);
    checkOutput("count_after_rst", 32'(nWords), 32'd96);
    checkOutput("first_after_rst", got[0], 32'h3020_1000);
    checkOutput("sb_empty_after_rst", 32'(sb.size()), 32'd0);

    // Inputs overwritten after the first word
    $display("[TB] inputs overwritten after start");
    applyStimulus();
`ifdef WB_SNAPSHOT_EN
    pushExpected(1'b0);
`else
    pushExpected(1'b1);
`endif
    runStream(1'b0, -1, -1, 1'b1);
    checkOutput("count_overwrite", 32'(nWords), 32'd96);
`ifdef WB_SNAPSHOT_EN
    checkOutput("overwrite_w1", got[1], 32'h3121_1101);
    checkOutput("overwrite_last", got[95], 32'hF7E7_7767);
`else
    checkOutput("overwrite_w1", got[1], 32'hFFFF_FFFF);
    checkOutput("overwrite_last", got[95], 32'hFFFF_FFFF);
`endif
    checkOutput("overwrite_w0", got[0], 32'h3020_1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
